// File: rtl/bomb_controller_pkg.sv
// Shared game definitions: FSM encodings, play-field clamp limits and a clamp helper.
// Pure declarations; no timing, no flow control.
package game_defs;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ARMED    = 2'b01,
      BLAST    = 2'b10,
      COOLDOWN = 2'b11
   } state_t;

   localparam int X_MIN = 26;
   localparam int X_MAX = 614;
   localparam int Y_MIN = 27;
   localparam int Y_MAX = 453;

   // Phase counters are sized generously; tick counts are small game constants.
   localparam int CNT_W = 16;

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/bomb_controller_tick_countdown.sv
// Loadable down-counter stepped by the game tick; zero is a same-cycle pulse on the 1->0 tick.
// Load wins over a coincident tick; no backpressure.
module tick_countdown #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   // Combinational so the FSM can react on the decisive tick and register its outputs 1 clk later.
   assign zero = en && !load && (count == W'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb lifecycle (drop, fuse, blast, cooldown) feeding the renderer's circle test.
// Outputs registered, 1 clk after the decisive tick or drop edge; drop edges outside IDLE are dropped.
module bomb_controller
   import game_defs::*;
#(
   parameter int POS_W       = 10,
   parameter int FUSE_TICKS  = 96,
   parameter int BLAST_TICKS = 32,
   parameter int COOL_TICKS  = 16,
   parameter int RAD_INIT    = 15,
   parameter int RAD_STEP    = 3,
   parameter int RAD_MAX     = 60
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             drop_req,
   input  logic [POS_W-1:0] player_x,
   input  logic [POS_W-1:0] player_y,
   output logic [POS_W-1:0] bomb_x,
   output logic [POS_W-1:0] bomb_y,
   output logic [POS_W-1:0] bomb_rad,
   output logic             bomb_visible,
   output logic             blast_active,
   output logic             exploded,
   output logic             busy,
   output logic [1:0]       state_o
);

   state_t           state;
   logic             drop_prev;
   logic             drop_rise;
   logic             load_fuse, load_blast, load_cool;
   logic             fuse_zero, blast_zero, cool_zero;
   logic [POS_W:0]   rad_sum;
   logic [POS_W-1:0] rad_next;

   assign drop_rise  = drop_req && !drop_prev;
   assign load_fuse  = (state == IDLE)  && drop_rise;
   assign load_blast = (state == ARMED) && fuse_zero;
   assign load_cool  = (state == BLAST) && blast_zero;
   assign state_o    = state;

   // One extra bit so the saturation compare sees the true sum instead of a wrapped one.
   assign rad_sum  = {1'b0, bomb_rad} + (POS_W+1)'(RAD_STEP);
   assign rad_next = (rad_sum > (POS_W+1)'(RAD_MAX)) ? POS_W'(RAD_MAX) : rad_sum[POS_W-1:0];

   tick_countdown #(.W(CNT_W)) u_fuse (
      .clk(clk), .reset(reset), .load(load_fuse), .load_val(CNT_W'(FUSE_TICKS)),
      .en(tick && (state == ARMED)), .zero(fuse_zero)
   );

   tick_countdown #(.W(CNT_W)) u_blast (
      .clk(clk), .reset(reset), .load(load_blast), .load_val(CNT_W'(BLAST_TICKS)),
      .en(tick && (state == BLAST)), .zero(blast_zero)
   );

   tick_countdown #(.W(CNT_W)) u_cool (
      .clk(clk), .reset(reset), .load(load_cool), .load_val(CNT_W'(COOL_TICKS)),
      .en(tick && (state == COOLDOWN)), .zero(cool_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         drop_prev    <= 1'b0;
         bomb_x       <= '0;
         bomb_y       <= '0;
         bomb_rad     <= '0;
         bomb_visible <= 1'b0;
         blast_active <= 1'b0;
         exploded     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         drop_prev <= drop_req;
         exploded  <= 1'b0;
         case (state)
            IDLE: begin
               if (drop_rise) begin
                  state        <= ARMED;
                  bomb_x       <= POS_W'(clamp(int'(player_x), X_MIN, X_MAX));
                  bomb_y       <= POS_W'(clamp(int'(player_y), Y_MIN, Y_MAX));
                  bomb_rad     <= POS_W'(RAD_INIT);
                  bomb_visible <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            ARMED: begin
               if (fuse_zero) begin
                  state        <= BLAST;
                  exploded     <= 1'b1;
                  blast_active <= 1'b1;
                  bomb_rad     <= POS_W'(RAD_INIT);
               end
            end
            BLAST: begin
               if (blast_zero) begin
                  state        <= COOLDOWN;
                  bomb_rad     <= '0;
                  bomb_visible <= 1'b0;
                  blast_active <= 1'b0;
               end else if (tick) begin
                  bomb_rad <= rad_next;
               end
            end
            COOLDOWN: begin
               if (cool_zero) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bomb_controller.sv
// Bench for bomb_controller: directed scenarios plus random ticks/drops against a tick-count model.
module tb_bomb_controller;

   localparam int FT = 4;
   localparam int BT = 20;
   localparam int CT = 3;
   localparam int RI = 15;
   localparam int RS = 3;
   localparam int RM = 60;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       drop_req;
   logic [9:0] player_x, player_y;
   logic [9:0] bomb_x, bomb_y, bomb_rad;
   logic       bomb_visible, blast_active, exploded, busy;
   logic [1:0] state_o;

   always #5 clk = ~clk;

   bomb_controller #(
      .POS_W(10), .FUSE_TICKS(FT), .BLAST_TICKS(BT), .COOL_TICKS(CT),
      .RAD_INIT(RI), .RAD_STEP(RS), .RAD_MAX(RM)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .drop_req(drop_req),
      .player_x(player_x), .player_y(player_y),
      .bomb_x(bomb_x), .bomb_y(bomb_y), .bomb_rad(bomb_rad),
      .bomb_visible(bomb_visible), .blast_active(blast_active),
      .exploded(exploded), .busy(busy), .state_o(state_o)
   );

   int pass_cnt = 0;
   int total_cnt = 0;

   // Model: a bomb is "ticks since acceptance" n; its phase follows from n alone.
   bit m_active, m_prev, m_expl;
   int m_n, m_bx, m_by;

   task automatic chk(input string tag, input int obs, input int exp);
      total_cnt++;
      if (obs == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task automatic model_reset();
      m_active = 0; m_prev = 0; m_expl = 0; m_n = 0; m_bx = 0; m_by = 0;
   endtask

   task automatic check_outputs();
      int ph, rad;
      if (!m_active)         ph = 0;
      else if (m_n < FT)     ph = 1;
      else if (m_n < FT+BT)  ph = 2;
      else                   ph = 3;
      if (ph == 1)      rad = RI;
      else if (ph == 2) rad = (RI + RS*(m_n-FT) > RM) ? RM : RI + RS*(m_n-FT);
      else              rad = 0;
      chk("state", int'(state_o), ph);
      chk("bomb_x", int'(bomb_x), m_bx);
      chk("bomb_y", int'(bomb_y), m_by);
      chk("bomb_rad", int'(bomb_rad), rad);
      chk("visible", int'(bomb_visible), int'(ph == 1 || ph == 2));
      chk("blast_active", int'(blast_active), int'(ph == 2));
      chk("exploded", int'(exploded), int'(m_expl));
      chk("busy", int'(busy), int'(m_active));
   endtask

   task automatic step(input bit t, input bit d, input int px, input int py);
      @(negedge clk);
      tick = t; drop_req = d; player_x = px[9:0]; player_y = py[9:0];
      m_expl = 0;
      if (!m_active) begin
         if (d && !m_prev) begin
            m_active = 1; m_n = 0;
            m_bx = clampi(px & 1023, 26, 614);
            m_by = clampi(py & 1023, 27, 453);
         end
      end else if (t) begin
         m_n++;
         if (m_n == FT) m_expl = 1;
         if (m_n == FT+BT+CT) m_active = 0;
      end
      m_prev = d;
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic run_to_idle(input bit toggle);
      for (int i = 0; i < 400 && m_active; i++)
         step(1'b1, toggle ? i[0] : 1'b1, 77, 88);
      chk("bounded_idle", int'(m_active), 0);
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; drop_req = 1'b0; player_x = '0; player_y = '0;
      model_reset();
      #12;
      check_outputs();
      @(negedge clk);
      reset = 1'b0;

      // Basic drop, full lifecycle with drop held high the whole time.
      step(0, 1, 100, 240);
      chk("t1_bomb_x", int'(bomb_x), 100);
      chk("t1_state", int'(state_o), 1);
      for (int i = 0; i < FT; i++) step(1, 1, 100, 240);
      chk("t1_exploded", int'(exploded), 1);
      run_to_idle(1'b0);
      step(0, 1, 1, 1);
      chk("t3_no_retrigger", int'(busy), 0);
      step(0, 0, 1, 1);
      step(0, 1, 300, 200);
      chk("t3_new_edge", int'(busy), 1);
      run_to_idle(1'b1);

      // Clamp corners, with drop toggling throughout the active phases.
      step(0, 0, 0, 0);
      step(0, 1, 5, 470);
      chk("t4_clamp_x", int'(bomb_x), 26);
      chk("t4_clamp_y", int'(bomb_y), 453);
      run_to_idle(1'b1);
      step(0, 0, 0, 0);
      step(0, 1, 700, 0);
      chk("t4_clamp_x2", int'(bomb_x), 614);
      chk("t4_clamp_y2", int'(bomb_y), 27);
      run_to_idle(1'b1);

      // Tick coincident with the accepting edge.
      step(0, 0, 0, 0);
      step(1, 1, 320, 240);
      for (int i = 0; i < FT-1; i++) step(1, 0, 0, 0);
      chk("t5_still_armed", int'(state_o), 1);
      run_to_idle(1'b0);

      // Asynchronous reset in the middle of the blast.
      step(0, 0, 0, 0);
      step(0, 1, 200, 210);
      for (int i = 0; i < FT+3; i++) step(1, 0, 0, 0);
      @(negedge clk);
      #2;
      tick = 1'b0; drop_req = 1'b0; reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 0, 0);
      step(0, 1, 50, 60);
      chk("t6_after_reset", int'(bomb_x), 50);
      run_to_idle(1'b0);

      // Random ticks, drop toggles and positions.
      begin
         bit d = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) d = ~d;
            step($urandom_range(0, 2) == 0, d,
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
